conv_tile_ctrl: RTL and testbench

//   Sequencer for the 3x3 PE array convolution tile (5x5 ifmap window, 3x3 filter, 9 psums).

---
 rtl/conv_tile_ctrl_pkg.sv | 32 +++
 rtl/conv_tile_ctrl_if.sv | 45 ++++
 rtl/conv_tile_ctrl_cycle_counter.sv | 42 ++++
 rtl/conv_tile_ctrl.sv | 149 ++++++++++++++
 tb/tb_conv_tile_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_tile_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : conv_ctrl_pkg
// Brief  : Shared widths and FSM state encoding for the 3x3 conv tile sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package conv_ctrl_pkg;

    localparam int DATA_W  = 16;
    localparam int IFMAP_N = 25;
    localparam int FILT_N  = 9;
    localparam int OUT_N   = 9;
    localparam int TILE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_tile_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : conv_tile_ctrl_if
// Brief  : Job, ifmap, PE-array and result signals of the conv tile sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface conv_tile_ctrl_if;
    import conv_ctrl_pkg::*;

    logic                        start;
    logic [TILE_W-1:0]           num_tiles;
    logic [FILT_N*DATA_W-1:0]    filter_flat;
    logic                        ifmap_valid;
    logic                        ifmap_ready;
    logic [IFMAP_N*DATA_W-1:0]   ifmap_flat;
    logic                        arr_rst;
    logic                        arr_en;
    logic [IFMAP_N*DATA_W-1:0]   arr_ifmap_flat;
    logic [FILT_N*DATA_W-1:0]    arr_filter_flat;
    logic [OUT_N*DATA_W-1:0]     arr_sum_flat;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_N*DATA_W-1:0]     out_data;
    logic [TILE_W-1:0]           out_tile_idx;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, num_tiles, filter_flat, ifmap_valid, ifmap_flat,
               arr_sum_flat, out_ready,
        output ifmap_ready, arr_rst, arr_en, arr_ifmap_flat, arr_filter_flat,
               out_valid, out_data, out_tile_idx, busy, done
    );

    modport slave (
        output start, num_tiles, filter_flat, ifmap_valid, ifmap_flat,
               arr_sum_flat, out_ready,
        input  ifmap_ready, arr_rst, arr_en, arr_ifmap_flat, arr_filter_flat,
               out_valid, out_data, out_tile_idx, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/conv_tile_ctrl_cycle_counter.sv
//------------------------------------------------------------------------------
// Module : cycle_counter
// Brief  : Up-counter 0..COUNT_N-1 with synchronous load-to-zero and a
//          terminal-count flag; times the array compute window.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cycle_counter
    import conv_ctrl_pkg::*;
#(
    parameter int COUNT_N = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_en,
    output logic      o_tc
);

    localparam int CNT_W = cnt_width(COUNT_N);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == CNT_W'(COUNT_N - 1));
    assign o_tc = w_tc;

    // Saturates at terminal count; the owner leaves the timed state on o_tc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_tile_ctrl.sv
//------------------------------------------------------------------------------
// Module : conv_tile_ctrl
// Brief  : Sequences N ifmap tiles through the 3x3 PE array with one shared
//          filter and hands each 3x3 result downstream.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_tile_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int COMPUTE_CYC = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv_tile_ctrl_if.master bus
);

    state_t                      r_state;
    logic [TILE_W-1:0]           r_num_tiles;
    logic [TILE_W-1:0]           r_tile_idx;
    logic [TILE_W-1:0]           r_out_tile_idx;
    logic [FILT_N*DATA_W-1:0]    r_filter;
    logic [IFMAP_N*DATA_W-1:0]   r_ifmap;
    logic [OUT_N*DATA_W-1:0]     r_out_data;
    logic                        r_ifmap_ready;
    logic                        r_arr_rst;
    logic                        r_arr_en;
    logic                        r_out_valid;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_cnt_load;
    logic                        w_cnt_en;
    logic                        w_cnt_tc;
    logic                        w_last_tile;
    logic                        w_ifmap_hs;
    logic                        w_out_hs;

    assign w_cnt_load  = (r_state == ST_LOAD);
    assign w_cnt_en    = (r_state == ST_COMPUTE);
    assign w_last_tile = (r_tile_idx == (r_num_tiles - TILE_W'(1)));
    assign w_ifmap_hs  = bus.ifmap_valid & r_ifmap_ready;
    assign w_out_hs    = bus.out_ready & r_out_valid;

    cycle_counter #(
        .COUNT_N (COMPUTE_CYC)
    ) u_compute_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_en   (w_cnt_en),
        .o_tc   (w_cnt_tc)
    );

    // Handshake outputs are registered alongside the state so that no input
    // reaches them combinationally; ready/valid are only high in their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_num_tiles    <= '0;
            r_tile_idx     <= '0;
            r_out_tile_idx <= '0;
            r_filter       <= '0;
            r_ifmap        <= '0;
            r_out_data     <= '0;
            r_ifmap_ready  <= 1'b0;
            r_arr_rst      <= 1'b0;
            r_arr_en       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_tiles != '0) begin
                            r_filter      <= bus.filter_flat;
                            r_num_tiles   <= bus.num_tiles;
                            r_tile_idx    <= '0;
                            r_ifmap_ready <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= ST_FETCH;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_ifmap_hs) begin
                        r_ifmap       <= bus.ifmap_flat;
                        r_ifmap_ready <= 1'b0;
                        r_arr_rst     <= 1'b1;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_arr_rst <= 1'b0;
                    r_arr_en  <= 1'b1;
                    r_state   <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (w_cnt_tc) begin
                        r_arr_en       <= 1'b0;
                        r_out_data     <= bus.arr_sum_flat;
                        r_out_tile_idx <= r_tile_idx;
                        r_out_valid    <= 1'b1;
                        r_state        <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (w_last_tile) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_tile_idx    <= r_tile_idx + TILE_W'(1);
                            r_ifmap_ready <= 1'b1;
                            r_state       <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ifmap_ready     = r_ifmap_ready;
    assign bus.arr_rst         = r_arr_rst;
    assign bus.arr_en          = r_arr_en;
    assign bus.arr_ifmap_flat  = r_ifmap;
    assign bus.arr_filter_flat = r_filter;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_data        = r_out_data;
    assign bus.out_tile_idx    = r_out_tile_idx;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_conv_tile_ctrl
// Brief  : Randomized scoreboard bench for conv_tile_ctrl with a behavioural
//          3x3 convolution array model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_tile_ctrl;
    import conv_ctrl_pkg::*;

    localparam int COMPUTE_CYC = 8;
    localparam int LAT         = COMPUTE_CYC + 2;
    localparam int BIAS        = COMPUTE_CYC - 1;

    typedef struct {
        logic [OUT_N*DATA_W-1:0] d;
        logic [TILE_W-1:0]       idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t sb[$];
    int   accept_cyc  = 0;
    int   exp_done_at = -1;
    int   job_tiles   = 0;
    int   out_count   = 0;
    bit   job_done    = 1'b0;
    bit   busy_next   = 1'b0;
    int   rmode       = 0;

    conv_tile_ctrl_if bus ();

    conv_tile_ctrl #(.COMPUTE_CYC(COMPUTE_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain 3x3 valid convolution over the 5x5 window plus a bias term.
    function automatic logic [OUT_N*DATA_W-1:0] conv_fn(
        input logic [IFMAP_N*DATA_W-1:0] im,
        input logic [FILT_N*DATA_W-1:0]  fl,
        input logic [DATA_W-1:0]         bias);
        logic [OUT_N*DATA_W-1:0] res;
        logic [DATA_W-1:0]       acc;
        logic [DATA_W-1:0]       a;
        logic [DATA_W-1:0]       b;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc = bias;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        a   = im[((r + i) * 5 + c + j) * DATA_W +: DATA_W];
                        b   = fl[(i * 3 + j) * DATA_W +: DATA_W];
                        acc = acc + a * b;
                    end
                end
                res[(r * 3 + c) * DATA_W +: DATA_W] = acc;
            end
        end
        return res;
    endfunction

    // Array model: counts enabled cycles since the last clear strobe.
    logic [DATA_W-1:0] arr_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)              arr_cnt <= '0;
        else if (bus.arr_rst) arr_cnt <= '0;
        else if (bus.arr_en)  arr_cnt <= arr_cnt + 1'b1;
    end
    assign bus.arr_sum_flat = conv_fn(bus.arr_ifmap_flat, bus.arr_filter_flat, arr_cnt);

    function automatic logic [IFMAP_N*DATA_W-1:0] rand_ifmap();
        logic [IFMAP_N*DATA_W-1:0] v;
        for (int k = 0; k < IFMAP_N; k++) v[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    function automatic logic [FILT_N*DATA_W-1:0] rand_filt();
        logic [FILT_N*DATA_W-1:0] v;
        for (int k = 0; k < FILT_N; k++) v[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"},   bus.out_valid, 0);
        chk({tag, "_busy"},        bus.busy, 0);
        chk({tag, "_done"},        bus.done, 0);
        chk({tag, "_arr_en"},      bus.arr_en, 0);
        chk({tag, "_arr_rst"},     bus.arr_rst, 0);
        chk({tag, "_ifmap_ready"}, bus.ifmap_ready, 0);
        chk({tag, "_out_data"},    bus.out_data, 0);
        chk({tag, "_out_idx"},     bus.out_tile_idx, 0);
        chk({tag, "_arr_ifmap"},   bus.arr_ifmap_flat, 0);
        chk({tag, "_arr_filter"},  bus.arr_filter_flat, 0);
    endtask

    // Monitor: pops the scoreboard on each result handshake and checks timing.
    logic                    prev_ov = 1'b0;
    logic                    prev_or = 1'b0;
    logic [OUT_N*DATA_W-1:0] prev_data;
    logic [TILE_W-1:0]       prev_idx;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.arr_rst || bus.arr_en) chk("arr_excl", bus.arr_rst & bus.arr_en, 0);
                if (bus.out_valid) begin
                    chk("ifmap_rdy_in_output", bus.ifmap_ready, 0);
                    if (!prev_ov) begin
                        chk("latency", cyc - accept_cyc, LAT);
                    end else if (!prev_or) begin
                        chk("hold_data", bus.out_data, prev_data);
                        chk("hold_idx", bus.out_tile_idx, prev_idx);
                    end
                    if (bus.out_ready) begin
                        if (sb.size() == 0) begin
                            chk("sb_empty", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("out_data", bus.out_data, e.d);
                            chk("out_idx", bus.out_tile_idx, e.idx);
                        end
                        out_count++;
                        if (out_count == job_tiles) exp_done_at = cyc + 1;
                    end
                end
                if (busy_next) begin
                    chk("busy_after_done", bus.busy, 0);
                    busy_next = 1'b0;
                end
                if (bus.done || cyc == exp_done_at) begin
                    chk("done", bus.done, cyc == exp_done_at);
                    if (bus.done) begin
                        chk("busy_at_done", bus.busy, job_tiles != 0);
                        busy_next = 1'b1;
                        job_done  = 1'b1;
                    end
                    exp_done_at = -1;
                end
                prev_ov   = bus.out_valid;
                prev_or   = bus.out_ready;
                prev_data = bus.out_data;
                prev_idx  = bus.out_tile_idx;
            end
        end
    end

    // Downstream: always ready, random, or stall 5 cycles per result.
    initial begin
        int lowcnt = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom % 2);
                default: begin
                    if (bus.out_valid) begin
                        if (lowcnt < 5) begin
                            bus.out_ready = 1'b0;
                            lowcnt++;
                        end else begin
                            bus.out_ready = 1'b1;
                        end
                    end else begin
                        bus.out_ready = 1'b0;
                        lowcnt = 0;
                    end
                end
            endcase
        end
    end

    task automatic run_job(input int n, input bit keep, input bit fixed, input bit poke);
        logic [FILT_N*DATA_W-1:0]  f;
        logic [IFMAP_N*DATA_W-1:0] im;
        int   guard;
        int   dly;
        exp_t e;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.busy && guard < 500);
        if (fixed) for (int k = 0; k < FILT_N; k++) f[k*DATA_W +: DATA_W] = DATA_W'(1);
        else       f = rand_filt();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_tiles = TILE_W'(n); bus.filter_flat = f;
        job_tiles = n; out_count = 0; job_done = 1'b0;
        if (n == 0) exp_done_at = cyc + 1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.num_tiles = TILE_W'($urandom); bus.filter_flat = rand_filt();
        if (n == 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("zero_job_busy", bus.busy, 0);
                chk("zero_job_arr", {bus.arr_rst, bus.arr_en}, 0);
            end
        end
        for (int t = 0; t < n; t++) begin
            dly = keep ? 0 : $urandom_range(0, 2);
            guard = 0;
            forever begin
                @(negedge clk);
                if (bus.ifmap_ready) begin
                    if (dly == 0) break;
                    bus.ifmap_valid = 1'b0;
                    dly--;
                end
                guard++;
                if (guard > 300) begin
                    chk("ifmap_ready_timeout", 0, 1);
                    return;
                end
            end
            if (fixed) for (int k = 0; k < IFMAP_N; k++) im[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
            else       im = rand_ifmap();
            bus.ifmap_flat = im; bus.ifmap_valid = 1'b1; accept_cyc = cyc;
            e.d = conv_fn(im, f, DATA_W'(BIAS)); e.idx = TILE_W'(t);
            sb.push_back(e);
            @(posedge clk); #1;
            bus.ifmap_valid = keep ? 1'b1 : 1'($urandom % 2);
            bus.ifmap_flat  = rand_ifmap();
            if (poke && t == 0) begin
                repeat (3) @(posedge clk);
                #1;
                bus.start = 1'b1; bus.num_tiles = TILE_W'($urandom);
                bus.filter_flat = rand_filt(); bus.ifmap_valid = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                @(negedge clk);
                chk("filter_held", bus.arr_filter_flat, f);
                chk("busy_held", bus.busy, 1);
            end
        end
        bus.ifmap_valid = 1'b0;
        guard = 0;
        while (!job_done && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!job_done) chk("job_timeout", 0, 1);
    endtask

    initial begin
        int guard;
        bus.start = 1'b0; bus.num_tiles = '0; bus.filter_flat = '0;
        bus.ifmap_valid = 1'b0; bus.ifmap_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        rmode = 0; run_job(1, 1'b0, 1'b1, 1'b0);
        rmode = 0; run_job(3, 1'b1, 1'b0, 1'b0);
        rmode = 2; run_job(2, 1'b0, 1'b0, 1'b0);
        rmode = 0; run_job(0, 1'b0, 1'b0, 1'b0);
        rmode = 1; run_job(2, 1'b0, 1'b0, 1'b1);

        // Abort a job in the middle of the compute window.
        rmode = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_tiles = TILE_W'(2); bus.filter_flat = rand_filt();
        job_tiles = 2; out_count = 0; job_done = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.ifmap_ready && guard < 100);
        chk("abort_fetch_ready", bus.ifmap_ready, 1);
        bus.ifmap_flat = rand_ifmap(); bus.ifmap_valid = 1'b1;
        @(posedge clk); #1;
        bus.ifmap_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_en", bus.arr_en, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        sb.delete(); exp_done_at = -1; busy_next = 1'b0; job_tiles = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_busy", bus.busy, 0);
        run_job(1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rmode = int'($urandom % 3);
            run_job($urandom_range(1, 3), 1'($urandom % 2), 1'b0, 1'($urandom % 2));
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
